otg_hpi_sequencer: RTL and testbench

//  Sequences CY7C67200 HPI bus cycles and shares the HPI between two requesters (0: NIOS driver, 1: HW poller).

---
 rtl/otg_hpi_sequencer_if.sv | 41 ++++
 rtl/otg_hpi_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_otg_hpi_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/otg_hpi_sequencer_if.sv
// Requester and HPI pad bundle for otg_hpi_sequencer.
// The slave modport is the sequencer; the master modport is the requester/pad side.
interface otg_hpi_sequencer_if;
    logic        req0_valid;
    logic        req0_we;
    logic        req0_reg;
    logic [15:0] req0_addr;
    logic [15:0] req0_wdata;
    logic        req0_ack;
    logic        req1_valid;
    logic        req1_we;
    logic        req1_reg;
    logic [15:0] req1_addr;
    logic [15:0] req1_wdata;
    logic        req1_ack;
    logic [15:0] rdata;
    logic        busy;
    logic [1:0]  hpi_addr;
    logic        hpi_cs_n;
    logic        hpi_rd_n;
    logic        hpi_wr_n;
    logic [15:0] hpi_dout;
    logic        hpi_doe;
    logic [15:0] hpi_din;

    modport slave (
        input  req0_valid, req0_we, req0_reg, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_reg, req1_addr, req1_wdata,
        input  hpi_din,
        output req0_ack, req1_ack, rdata, busy,
        output hpi_addr, hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_dout, hpi_doe
    );

    modport master (
        output req0_valid, req0_we, req0_reg, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_reg, req1_addr, req1_wdata,
        output hpi_din,
        input  req0_ack, req1_ack, rdata, busy,
        input  hpi_addr, hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_dout, hpi_doe
    );
endinterface

// File: rtl/otg_hpi_sequencer.sv
// CY7C67200 HPI bus-cycle sequencer with round-robin sharing between two requesters.
// Optional HPI_ADDR_SKIP_EN: skip the ADDRESS cycle when the chip's auto-increment already matches.
module otg_hpi_sequencer #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned RECOV_CYC  = 2
) (
    input logic                clk,
    input logic                reset_n,
    otg_hpi_sequencer_if.slave bus
);

    localparam logic [3:0] SetupLd  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] StrobeLd = 4'(STROBE_CYC - 1);
    localparam logic [3:0] RecovLd  = 4'(RECOV_CYC - 1);

    typedef enum logic [2:0] {
        StIdle, StASetup, StAStrobe, StARecov, StDSetup, StDStrobe, StDRecov, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic        reg_q, reg_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] rdata_q, rdata_d;
    logic [1:0]  hpi_addr_q, hpi_addr_d;

    logic [1:0]  req_valid;
    logic        sel, sel_we, sel_reg;
    logic [15:0] sel_addr, sel_wdata;
    logic        skip;
    logic        phase_end;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    // On contention the requester that did not win last time gets the bus.
    assign sel       = (&req_valid) ? ~last_q : req_valid[1];
    assign sel_we    = sel ? bus.req1_we    : bus.req0_we;
    assign sel_reg   = sel ? bus.req1_reg   : bus.req0_reg;
    assign sel_addr  = sel ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = sel ? bus.req1_wdata : bus.req0_wdata;
    assign phase_end = (cnt_q == 4'd0);

`ifdef HPI_ADDR_SKIP_EN
    logic [15:1] addr_q, addr_d;
    logic [15:0] pred_addr_q, pred_addr_d;
    logic        pred_valid_q, pred_valid_d;

    assign skip = pred_valid_q && !sel_reg && (sel_addr[15:1] == pred_addr_q[15:1]);

    // Mirror of the chip's ADDRESS register, which post-increments on every DATA access.
    always_comb begin
        pred_addr_d  = pred_addr_q;
        pred_valid_d = pred_valid_q;
        addr_d       = addr_q;
        if (state_q == StIdle && |req_valid) begin
            addr_d = sel_addr[15:1];
            if (sel_reg) pred_valid_d = 1'b0;
        end
        if (state_q == StAStrobe && phase_end) begin
            pred_addr_d  = {addr_q, 1'b0};
            pred_valid_d = 1'b1;
        end
        if (state_q == StDStrobe && phase_end && !reg_q) pred_addr_d = pred_addr_q + 16'd2;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q       <= '0;
            pred_addr_q  <= '0;
            pred_valid_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            pred_addr_q  <= pred_addr_d;
            pred_valid_q <= pred_valid_d;
        end
    end
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        we_d       = we_q;
        reg_d      = reg_q;
        wdata_d    = wdata_q;
        dout_d     = dout_q;
        rdata_d    = rdata_q;
        hpi_addr_d = hpi_addr_q;
        if (state_q != StIdle && state_q != StDone) cnt_d = cnt_q - 4'd1;
        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    gnt_d   = sel;
                    last_d  = sel;
                    we_d    = sel_we;
                    reg_d   = sel_reg;
                    wdata_d = sel_wdata;
                    cnt_d   = SetupLd;
                    if (sel_reg || skip) begin
                        state_d    = StDSetup;
                        hpi_addr_d = sel_reg ? sel_addr[1:0] : 2'd0;
                        if (sel_we) dout_d = sel_wdata;
                    end else begin
                        state_d    = StASetup;
                        hpi_addr_d = 2'd2;
                        dout_d     = {sel_addr[15:1], 1'b0};
                    end
                end
            end
            StASetup: if (phase_end) begin
                state_d = StAStrobe;
                cnt_d   = StrobeLd;
            end
            StAStrobe: if (phase_end) begin
                state_d = StARecov;
                cnt_d   = RecovLd;
            end
            StARecov: if (phase_end) begin
                state_d    = StDSetup;
                cnt_d      = SetupLd;
                hpi_addr_d = 2'd0;
                if (we_q) dout_d = wdata_q;
            end
            StDSetup: if (phase_end) begin
                state_d = StDStrobe;
                cnt_d   = StrobeLd;
            end
            StDStrobe: if (phase_end) begin
                state_d = StDRecov;
                cnt_d   = RecovLd;
                if (!we_q) rdata_d = bus.hpi_din;
            end
            StDRecov: if (phase_end) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            we_q       <= 1'b0;
            reg_q      <= 1'b0;
            wdata_q    <= '0;
            dout_q     <= '0;
            rdata_q    <= '0;
            hpi_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            we_q       <= we_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            dout_q     <= dout_d;
            rdata_q    <= rdata_d;
            hpi_addr_q <= hpi_addr_d;
        end
    end

    // Pad controls decode straight from state so reset forces them idle at the same edge.
    assign bus.hpi_cs_n = !(state_q inside {StASetup, StAStrobe, StDSetup, StDStrobe});
    assign bus.hpi_doe  = (state_q inside {StASetup, StAStrobe}) ||
                          ((state_q inside {StDSetup, StDStrobe}) && we_q);
    assign bus.hpi_wr_n = !((state_q == StAStrobe) || ((state_q == StDStrobe) && we_q));
    assign bus.hpi_rd_n = !((state_q == StDStrobe) && !we_q);
    assign bus.hpi_addr = hpi_addr_q;
    assign bus.hpi_dout = dout_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.req0_ack = (state_q == StDone) && !gnt_q;
    assign bus.req1_ack = (state_q == StDone) && gnt_q;

endmodule

// File: tb/tb_otg_hpi_sequencer.sv
// Scoreboard bench for otg_hpi_sequencer: stimulus queues expected acks and HPI cycles,
// independent monitors pop and compare them and watch the pad protocol.
module tb_otg_hpi_sequencer;

    localparam int StrobeCyc = 4;
    localparam int RecovCyc  = 2;
    localparam int MemLat    = 15;
    localparam int RegLat    = 8;
`ifdef HPI_ADDR_SKIP_EN
    localparam bit SkipEn = 1'b1;
`else
    localparam bit SkipEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    otg_hpi_sequencer_if bus ();

    otg_hpi_sequencer #(
        .SETUP_CYC  (1),
        .STROBE_CYC (StrobeCyc),
        .RECOV_CYC  (RecovCyc)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        int          cyc;
        bit          chk;
        logic [15:0] data;
    } ack_t;
    typedef struct {
        logic [1:0]  addr;
        bit          we;
        logic [15:0] data;
    } bus_t;

    ack_t ack_q[$];
    bus_t bus_q[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void exp_ack(int id, int at, bit chk, logic [15:0] data);
        ack_q.push_back('{id, at, chk, data});
    endfunction

    function automatic void exp_bus(logic [1:0] addr, bit we, logic [15:0] data);
        bus_q.push_back('{addr, we, data});
    endfunction

    // Ack scoreboard
    always @(negedge clk) begin
        ack_t e;
        if (bus.req0_ack || bus.req1_ack) begin
            check("ack_expected", 32'(ack_q.size() != 0), 1);
            if (ack_q.size() != 0) begin
                e = ack_q.pop_front();
                check("ack_id", {bus.req1_ack, bus.req0_ack}, (e.id == 0) ? 2'b01 : 2'b10);
                check("ack_cycle", cyc, e.cyc);
                if (e.chk) check("rdata", bus.rdata, e.data);
            end
        end
    end

    // HPI cycle scoreboard and protocol watcher
    bit strobe_prev = 1'b0;
    int lo_cnt = 0;
    int hi_cnt = RecovCyc;
    always @(negedge clk) begin
        bus_t e;
        bit strobe;
        strobe = !bus.hpi_rd_n || !bus.hpi_wr_n;
        if (!reset_n) begin
            lo_cnt = 0;
            hi_cnt = RecovCyc;
        end else begin
            if (strobe && !strobe_prev) begin
                check("bus_cycle_expected", 32'(bus_q.size() != 0), 1);
                if (bus_q.size() != 0) begin
                    e = bus_q.pop_front();
                    check("bus_addr", bus.hpi_addr, e.addr);
                    check("bus_we", !bus.hpi_wr_n, e.we);
                    if (e.we) check("bus_dout", bus.hpi_dout, e.data);
                end
            end
            if (strobe) begin
                check("strobe_cs", bus.hpi_cs_n, 0);
                check("rd_wr_overlap", bus.hpi_rd_n | bus.hpi_wr_n, 1);
                if (!bus.hpi_rd_n) check("doe_in_read", bus.hpi_doe, 0);
                lo_cnt++;
            end else if (lo_cnt != 0) begin
                check("strobe_len", lo_cnt, StrobeCyc);
                lo_cnt = 0;
            end
            if (bus.hpi_cs_n) hi_cnt++;
            else begin
                if (hi_cnt != 0) check("recov_len", 32'(hi_cnt >= RecovCyc), 1);
                hi_cnt = 0;
                check("cs_while_busy", bus.busy, 1);
            end
        end
        strobe_prev = strobe;
    end

    task automatic drive(int id, bit we, bit rg, logic [15:0] a, logic [15:0] wd);
        if (id == 0) begin
            bus.req0_we = we; bus.req0_reg = rg; bus.req0_addr = a; bus.req0_wdata = wd;
            bus.req0_valid = 1'b1;
        end else begin
            bus.req1_we = we; bus.req1_reg = rg; bus.req1_addr = a; bus.req1_wdata = wd;
            bus.req1_valid = 1'b1;
        end
    endtask

    task automatic wait_ack(int id);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (id == 0) ? bus.req0_ack : bus.req1_ack;
        end
        check("ack_arrived", 32'(seen), 1);
        if (id == 0) bus.req0_valid = 1'b0;
        else         bus.req1_valid = 1'b0;
    endtask

    task automatic txn(int id, bit we, bit rg, logic [15:0] a, logic [15:0] wd,
                       int lat, bit chk, logic [15:0] rd);
        @(negedge clk);
        exp_ack(id, cyc + lat, chk, rd);
        drive(id, we, rg, a, wd);
        wait_ack(id);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        int c;
        int acks;
        bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_reg = 1'b0;
        bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_reg = 1'b0;
        bus.req1_addr = '0; bus.req1_wdata = '0;
        bus.hpi_din = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", bus.hpi_cs_n, 1);
        check("rst_rd_n", bus.hpi_rd_n, 1);
        check("rst_wr_n", bus.hpi_wr_n, 1);
        check("rst_doe", bus.hpi_doe, 0);
        check("rst_addr", bus.hpi_addr, 0);
        check("rst_dout", bus.hpi_dout, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_acks", {bus.req1_ack, bus.req0_ack}, 0);
        check("rst_busy", bus.busy, 0);
        reset_n = 1'b1;

        // Memory write: ADDRESS then DATA cycle
        exp_bus(2'd2, 1'b1, 16'h1000);
        exp_bus(2'd0, 1'b1, 16'hBEEF);
        txn(0, 1'b1, 1'b0, 16'h1000, 16'hBEEF, MemLat, 1'b0, 16'h0);

        // Register read of STATUS
        bus.hpi_din = 16'h0A5A;
        exp_bus(2'd3, 1'b0, 16'h0);
        txn(1, 1'b0, 1'b1, 16'h0003, 16'h0, RegLat, 1'b1, 16'h0A5A);
        bus.hpi_din = 16'h0000;
        @(negedge clk);
        check("rdata_hold", bus.rdata, 16'h0A5A);

        // Contention straight out of reset: req0 first
        do_reset();
        bus.hpi_din = 16'h1234;
        @(negedge clk);
        c = cyc;
        exp_bus(2'd1, 1'b1, 16'h1111);
        exp_bus(2'd2, 1'b1, 16'h2000);
        exp_bus(2'd0, 1'b0, 16'h0);
        exp_ack(0, c + RegLat, 1'b0, 16'h0);
        exp_ack(1, c + RegLat + 1 + MemLat, 1'b1, 16'h1234);
        drive(0, 1'b1, 1'b1, 16'h0001, 16'h1111);
        drive(1, 1'b0, 1'b0, 16'h2000, 16'h0);
        fork
            wait_ack(0);
            wait_ack(1);
        join

        // Both held: grants alternate 0,1,0,1
        bus.hpi_din = 16'h0A5A;
        @(negedge clk);
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            exp_bus((k % 2 == 0) ? 2'd1 : 2'd3, 1'b0, 16'h0);
            exp_ack(k % 2, c + RegLat + k * (RegLat + 1), 1'b1, 16'h0A5A);
        end
        drive(0, 1'b0, 1'b1, 16'h0001, 16'h0);
        drive(1, 1'b0, 1'b1, 16'h0003, 16'h0);
        acks = 0;
        for (int i = 0; i < 200 && acks < 4; i++) begin
            @(negedge clk);
            if (bus.req0_ack || bus.req1_ack) acks++;
        end
        check("alt_ack_count", acks, 4);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Reset during the DATA write strobe abandons the transaction
        @(negedge clk);
        exp_bus(2'd2, 1'b1, 16'h3000);
        exp_bus(2'd0, 1'b1, 16'h5555);
        drive(0, 1'b1, 1'b0, 16'h3000, 16'h5555);
        repeat (10) @(negedge clk);
        check("mid_d_strobe_wr_n", bus.hpi_wr_n, 0);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_cs_n", bus.hpi_cs_n, 1);
        check("abort_wr_n", bus.hpi_wr_n, 1);
        check("abort_doe", bus.hpi_doe, 0);
        check("abort_ack", bus.req0_ack, 0);
        check("abort_busy", bus.busy, 0);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Fresh request after the abort
        bus.hpi_din = 16'hCAFE;
        exp_bus(2'd2, 1'b1, 16'h4000);
        exp_bus(2'd0, 1'b0, 16'h0);
        txn(1, 1'b0, 1'b0, 16'h4000, 16'h0, MemLat, 1'b1, 16'hCAFE);

        // Reads across the 0xFFFE wrap, then a register access in between
        bus.hpi_din = 16'h1357;
        exp_bus(2'd2, 1'b1, 16'hFFFE);
        exp_bus(2'd0, 1'b0, 16'h0);
        txn(0, 1'b0, 1'b0, 16'hFFFE, 16'h0, MemLat, 1'b1, 16'h1357);
        bus.hpi_din = 16'h2468;
        if (!SkipEn) exp_bus(2'd2, 1'b1, 16'h0000);
        exp_bus(2'd0, 1'b0, 16'h0);
        txn(0, 1'b0, 1'b0, 16'h0000, 16'h0, SkipEn ? RegLat : MemLat, 1'b1, 16'h2468);
        bus.hpi_din = 16'h0A5A;
        exp_bus(2'd3, 1'b0, 16'h0);
        txn(1, 1'b0, 1'b1, 16'h0003, 16'h0, RegLat, 1'b1, 16'h0A5A);
        bus.hpi_din = 16'h7777;
        exp_bus(2'd2, 1'b1, 16'h0002);
        exp_bus(2'd0, 1'b0, 16'h0);
        txn(0, 1'b0, 1'b0, 16'h0002, 16'h0, MemLat, 1'b1, 16'h7777);

        repeat (5) @(negedge clk);
        check("ack_queue_drained", ack_q.size(), 0);
        check("bus_queue_drained", bus_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
